// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, register address type and x0 constant.
// Used by the register file top and its read ports.
package riscv_pkg;

  localparam int DATA_LENGTH     = 32;
  localparam int REG_ADDR_LENGTH = 5;
  localparam int INST_LENGTH     = 32;

  typedef logic [REG_ADDR_LENGTH-1:0] reg_addr_t;

  localparam reg_addr_t X0 = '0;

endpackage

// File: rtl/reg_file_rport.sv
// reg_file_rport: one combinational read port with x0 mask and reset mask.
// Ports: rst_n, i_rs, i_regs, i_rd/i_regWEn/i_wdata (bypass), o_data. Macro REG_FILE_BYPASS_EN.
module reg_file_rport #(
  parameter int DATA_LENGTH     = riscv_pkg::DATA_LENGTH,
  parameter int REG_ADDR_LENGTH = riscv_pkg::REG_ADDR_LENGTH,
  parameter int NREG            = 2**REG_ADDR_LENGTH
) (
  input  logic                       rst_n,
  input  logic [REG_ADDR_LENGTH-1:0] i_rs,
  input  logic [DATA_LENGTH-1:0]     i_regs [NREG],
  input  logic [REG_ADDR_LENGTH-1:0] i_rd,
  input  logic                       i_regWEn,
  input  logic [DATA_LENGTH-1:0]     i_wdata,
  output logic [DATA_LENGTH-1:0]     o_data
);

  import riscv_pkg::*;

  localparam logic [REG_ADDR_LENGTH-1:0] ZERO =
    REG_ADDR_LENGTH'(X0);

  logic is_x0;
  logic hit;

  assign is_x0 = (i_rs == ZERO);

`ifdef REG_FILE_BYPASS_EN
  // Write-first: the value being written this cycle is visible now.
  assign hit = i_regWEn && (i_rd != ZERO) && (i_rs == i_rd);
`else
  logic unused_bypass;
  assign unused_bypass = ^{i_rd, i_regWEn};
  assign hit = 1'b0;
`endif

  always_comb begin
    o_data = '0;
    if (!rst_n || is_x0) begin
      o_data = '0;
    end else if (hit) begin
      o_data = i_wdata;
    end else begin
      o_data = i_regs[i_rs];
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: WB-stage integer register file, 2 read ports, retired-write counter.
// Ports: clk, rst_n, i_rd, i_regWEn, i_wdata, i_rs1, i_rs2, o_rs1_data, o_rs2_data, o_wb_count. Macro REG_FILE_BYPASS_EN.
module reg_file_wb #(
  parameter int DATA_LENGTH     = riscv_pkg::DATA_LENGTH,
  parameter int REG_ADDR_LENGTH = riscv_pkg::REG_ADDR_LENGTH,
  parameter int CNT_LENGTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [REG_ADDR_LENGTH-1:0] i_rd,
  input  logic                       i_regWEn,
  input  logic [DATA_LENGTH-1:0]     i_wdata,
  input  logic [REG_ADDR_LENGTH-1:0] i_rs1,
  input  logic [REG_ADDR_LENGTH-1:0] i_rs2,
  output logic [DATA_LENGTH-1:0]     o_rs1_data,
  output logic [DATA_LENGTH-1:0]     o_rs2_data,
  output logic [CNT_LENGTH-1:0]      o_wb_count
);

  import riscv_pkg::*;

  localparam int NREG = 2**REG_ADDR_LENGTH;

  localparam logic [REG_ADDR_LENGTH-1:0] ZERO =
    REG_ADDR_LENGTH'(X0);

  logic [DATA_LENGTH-1:0] regs [NREG];
  logic                   commit;

  assign commit = i_regWEn && (i_rd != ZERO);

  // Entry 0 is never written, so it stays at its reset value of 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      o_wb_count <= '0;
    end else if (commit) begin
      regs[i_rd] <= i_wdata;
      o_wb_count <= o_wb_count + 1'b1;
    end
  end

  reg_file_rport #(
    .DATA_LENGTH    (DATA_LENGTH),
    .REG_ADDR_LENGTH(REG_ADDR_LENGTH),
    .NREG           (NREG)
  ) u_rport1 (
    .rst_n   (rst_n),
    .i_rs    (i_rs1),
    .i_regs  (regs),
    .i_rd    (i_rd),
    .i_regWEn(i_regWEn),
    .i_wdata (i_wdata),
    .o_data  (o_rs1_data)
  );

  reg_file_rport #(
    .DATA_LENGTH    (DATA_LENGTH),
    .REG_ADDR_LENGTH(REG_ADDR_LENGTH),
    .NREG           (NREG)
  ) u_rport2 (
    .rst_n   (rst_n),
    .i_rs    (i_rs2),
    .i_regs  (regs),
    .i_rd    (i_rd),
    .i_regWEn(i_regWEn),
    .i_wdata (i_wdata),
    .o_data  (o_rs2_data)
  );

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: randomized + directed bench for reg_file_wb against an array model.
// Two instances share stimulus: default counter width and a 4-bit counter.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd, rs1, rs2;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] r1, r2, cnt;
  logic [31:0] r1b, r2b;
  logic [3:0]  cnt4;

  logic [31:0] m [32];
  int unsigned mcnt;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  reg_file_wb u_dut (
    .clk(clk), .rst_n(rst_n), .i_rd(rd), .i_regWEn(we),
    .i_wdata(wdata), .i_rs1(rs1), .i_rs2(rs2),
    .o_rs1_data(r1), .o_rs2_data(r2), .o_wb_count(cnt)
  );

  reg_file_wb #(.CNT_LENGTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_rd(rd), .i_regWEn(we),
    .i_wdata(wdata), .i_rs1(rs1), .i_rs2(rs2),
    .o_rs1_data(r1b), .o_rs2_data(r2b), .o_wb_count(cnt4)
  );

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown(we));
    end
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] rs);
    if (!rst_n || rs == 5'd0) return 32'd0;
`ifdef REG_FILE_BYPASS_EN
    if (we && rd != 5'd0 && rs == rd) return wdata;
`endif
    return m[rs];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    mcnt = 0;
  endtask

  task automatic compare();
    logic [31:0] c4;
    c4 = 32'(mcnt % 16);
    chk("rs1", r1, exp_rd(rs1));
    chk("rs2", r2, exp_rd(rs2));
    chk("cnt", cnt, mcnt);
    chk("rs1_b", r1b, exp_rd(rs1));
    chk("rs2_b", r2b, exp_rd(rs2));
    chk("cnt4", {28'd0, cnt4}, c4);
  endtask

  task automatic set(input logic w, input logic [4:0] d,
                     input logic [31:0] v, input logic [4:0] a,
                     input logic [4:0] b);
    we = w; rd = d; wdata = v; rs1 = a; rs2 = b;
  endtask

  // Called just after a negedge; checks, then crosses one posedge.
  task automatic tick();
    #1 compare();
    @(posedge clk);
    if (rst_n && we && rd != 5'd0) begin
      m[rd] = wdata;
      mcnt++;
    end
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_clear();
    #1 compare();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set(0, 0, 0, 0, 0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    #1 chk("reset_cnt", cnt, 32'd0);
    chk("reset_rd", r1, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read on both ports.
    set(1, 10, 32'h12345678, 0, 0);
    tick();
    set(0, 0, 0, 10, 10);
    #1 chk("wr_rs1", r1, 32'h12345678);
    chk("wr_rs2", r2, 32'h12345678);
    chk("wr_cnt", cnt, 32'd1);
    tick();

    // x0 stays zero, no count.
    set(1, 0, 32'hFFFFFFFF, 0, 0);
    tick();
    #1 chk("x0_rd", r1, 32'd0);
    chk("x0_cnt", cnt, 32'd1);
    tick();

    // Write enable low.
    set(0, 3, 32'hAAAA0000, 3, 0);
    tick();
    #1 chk("gate_rd", r1, 32'd0);
    chk("gate_cnt", cnt, 32'd1);
    tick();

    // Same-cycle hazard.
    set(1, 7, 32'h1, 0, 0);
    tick();
    set(1, 7, 32'h2, 7, 7);
`ifdef REG_FILE_BYPASS_EN
    #1 chk("haz_same", r1, 32'h2);
`else
    #1 chk("haz_same", r1, 32'h1);
`endif
    tick();
    set(0, 0, 0, 7, 7);
    #1 chk("haz_next", r1, 32'h2);
    chk("haz_cnt", cnt, 32'd3);
    tick();

    // Async reset between edges.
    set(1, 5, 32'hDEADBEEF, 0, 0);
    tick();
    set(0, 0, 0, 5, 5);
    #1 chk("pre_rst", r1, 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    model_clear();
    #1 chk("rst_rd", r1, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    // Write attempted during reset is blocked.
    set(1, 5, 32'h55, 5, 5);
    tick();
    rst_n = 1'b1;
    set(0, 0, 0, 5, 5);
    #1 chk("rst_blk", r1, 32'd0);
    tick();

    // Counter wrap on the 4-bit instance.
    for (int i = 0; i < 17; i++) begin
      set(1, 5'(i % 31 + 1), $urandom, 5'(i), 5'(i + 1));
      tick();
    end
    set(0, 0, 0, 0, 0);
    #1 chk("wrap4", {28'd0, cnt4}, 32'd1);
    chk("wrap32", cnt, 32'd17);
    tick();

    // Random traffic with occasional mid-cycle reset.
    for (int i = 0; i < 2000; i++) begin
      logic [4:0] d;
      d = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      set(1'($urandom), d, $urandom,
          ($urandom_range(0, 2) == 0) ? d : 5'($urandom),
          ($urandom_range(0, 2) == 0) ? d : 5'($urandom));
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule
